// File: rtl/mem_pattern_test.sv
// Burst memory self-test master: writes a pattern burst, reads it straight back and checks every beat.
// Write beat data lands one cycle after wr_burst_data_req; beats only advance on the master's req/valid, requests held until finish.
module mem_pattern_test #(
    parameter int                   MEM_DATA_BITS = 64,
    parameter int                   ADDR_BITS     = 32,
    parameter int                   BURST_LEN     = 128,
    parameter logic [ADDR_BITS-1:0] BASE_ADDR     = 'h2000000,
    parameter int                   ADDR_STEP     = 128,
    parameter int                   REGION_LEN    = 'h2000000
) (
    input  logic                     mem_clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     stop,
    input  logic [1:0]               mode,
    input  logic                     loop_en,
    output logic                     wr_burst_req,
    output logic [9:0]               wr_burst_len,
    output logic [ADDR_BITS-1:0]     wr_burst_addr,
    input  logic                     wr_burst_data_req,
    output logic [MEM_DATA_BITS-1:0] wr_burst_data,
    input  logic                     wr_burst_finish,
    output logic                     rd_burst_req,
    output logic [9:0]               rd_burst_len,
    output logic [ADDR_BITS-1:0]     rd_burst_addr,
    input  logic                     rd_burst_data_valid,
    input  logic [MEM_DATA_BITS-1:0] rd_burst_data,
    input  logic                     rd_burst_finish,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [15:0]              err_cnt,
    output logic [ADDR_BITS-1:0]     err_addr,
    output logic [15:0]              pass_cnt
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    state_t         state_q, state_d;
    logic [1:0]     mode_q;
    logic           loop_q;
    logic           stop_q;
    logic [9:0]     wr_beat, rd_beat;
    logic [31:0]    wr_lfsr, rd_lfsr;
    logic [31:0]    total_q;

    logic           start_go, wr_done, rd_done, stop_seen, region_end, rd_mismatch;
    logic [ADDR_BITS-1:0] step_addr;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    function automatic logic [31:0] lfsr_seed(input logic [ADDR_BITS-1:0] a);
        return 32'(a) | 32'd1;
    endfunction

    function automatic logic [MEM_DATA_BITS-1:0] pattern(input logic [1:0] m,
                                                         input logic [ADDR_BITS-1:0] a,
                                                         input logic [9:0] k,
                                                         input logic [31:0] lf);
        logic [MEM_DATA_BITS-1:0] p;
        logic [31:0]              w;
        p = '0;
        w = 32'(a) + {22'd0, k};
        case (m)
            2'd0:    p = {(MEM_DATA_BITS/8){k[7:0]}};
            2'd1:    p = {(MEM_DATA_BITS/32){w}};
            2'd2:    p = {{(MEM_DATA_BITS-1){1'b0}}, 1'b1} << (32'(k) % 32'(MEM_DATA_BITS));
            default: p = {(MEM_DATA_BITS/32){lf}};
        endcase
        return p;
    endfunction

    assign wr_burst_len = 10'(BURST_LEN);
    assign rd_burst_len = 10'(BURST_LEN);

    assign start_go    = start && (state_q == IDLE || state_q == DONE);
    assign wr_done     = (state_q == WRITE) && wr_burst_finish;
    assign rd_done     = (state_q == READ) && rd_burst_finish;
    assign stop_seen   = stop_q || stop;
    assign region_end  = total_q == 32'(REGION_LEN);
    assign step_addr   = wr_burst_addr + ADDR_BITS'(ADDR_STEP);
    assign rd_mismatch = rd_burst_data != pattern(mode_q, rd_burst_addr, rd_beat, rd_lfsr);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = WRITE;
            WRITE:      if (wr_burst_finish) state_d = READ;
            READ: begin
                if (rd_burst_finish) begin
                    if (stop_seen)                state_d = IDLE;
                    else if (region_end && !loop_q) state_d = DONE;
                    else                          state_d = WRITE;
                end
            end
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge mem_clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            mode_q        <= 2'd0;
            loop_q        <= 1'b0;
            stop_q        <= 1'b0;
            wr_beat       <= '0;
            rd_beat       <= '0;
            wr_lfsr       <= '0;
            rd_lfsr       <= '0;
            total_q       <= '0;
            wr_burst_req  <= 1'b0;
            wr_burst_addr <= '0;
            wr_burst_data <= '0;
            rd_burst_req  <= 1'b0;
            rd_burst_addr <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            err_cnt       <= '0;
            err_addr      <= '0;
            pass_cnt      <= '0;
        end else begin
            state_q <= state_d;
            if (busy && stop) stop_q <= 1'b1;

            if (start_go) begin
                mode_q        <= mode;
                loop_q        <= loop_en;
                stop_q        <= 1'b0;
                error         <= 1'b0;
                err_cnt       <= '0;
                err_addr      <= '0;
                pass_cnt      <= '0;
                done          <= 1'b0;
                busy          <= 1'b1;
                total_q       <= '0;
                wr_burst_addr <= BASE_ADDR;
                wr_burst_req  <= 1'b1;
                wr_beat       <= '0;
                wr_lfsr       <= lfsr_seed(BASE_ADDR);
            end

            if (state_q == WRITE && wr_burst_data_req) begin
                wr_burst_data <= pattern(mode_q, wr_burst_addr, wr_beat, wr_lfsr);
                wr_beat       <= wr_beat + 10'd1;
                wr_lfsr       <= lfsr_step(wr_lfsr);
            end

            // A final beat coincident with finish is taken first; the clear below then wins.
            if (wr_done) begin
                wr_burst_req  <= 1'b0;
                wr_beat       <= '0;
                rd_burst_req  <= 1'b1;
                rd_burst_addr <= wr_burst_addr;
                total_q       <= total_q + 32'(BURST_LEN);
                rd_beat       <= '0;
                rd_lfsr       <= lfsr_seed(wr_burst_addr);
            end

            if (state_q == READ && rd_burst_data_valid) begin
                rd_beat <= rd_beat + 10'd1;
                rd_lfsr <= lfsr_step(rd_lfsr);
                if (rd_mismatch) begin
                    error <= 1'b1;
                    if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                    if (err_cnt == 16'd0)    err_addr <= rd_burst_addr + ADDR_BITS'(rd_beat);
                end
            end

            if (rd_done) begin
                rd_burst_req <= 1'b0;
                rd_beat      <= '0;
                if (stop_seen) begin
                    busy <= 1'b0;
                    done <= 1'b0;
                end else if (region_end) begin
                    pass_cnt <= pass_cnt + 16'd1;
                    if (loop_q) begin
                        total_q       <= '0;
                        wr_burst_addr <= BASE_ADDR;
                        wr_burst_req  <= 1'b1;
                        wr_beat       <= '0;
                        wr_lfsr       <= lfsr_seed(BASE_ADDR);
                    end else begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                end else begin
                    wr_burst_addr <= step_addr;
                    wr_burst_req  <= 1'b1;
                    wr_beat       <= '0;
                    wr_lfsr       <= lfsr_seed(step_addr);
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_pattern_test.sv
// Bench for mem_pattern_test: memory-backed burst slave, queued expectations for write traffic, directed status checks.
module tb_mem_pattern_test;

    localparam int          BL   = 128;
    localparam logic [31:0] BASE = 32'h0200_0000;

    logic        mem_clk = 1'b0;
    logic        rst_n = 1'b0, start = 1'b0, stop = 1'b0, loop_en = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        wr_burst_req, rd_burst_req;
    logic [9:0]  wr_burst_len, rd_burst_len;
    logic [31:0] wr_burst_addr, rd_burst_addr, err_addr;
    logic [63:0] wr_burst_data;
    logic        wr_burst_data_req = 1'b0, wr_burst_finish = 1'b0;
    logic        rd_burst_data_valid = 1'b0, rd_burst_finish = 1'b0;
    logic [63:0] rd_burst_data = '0;
    logic        busy, done, error;
    logic [15:0] err_cnt, pass_cnt;

    mem_pattern_test #(
        .MEM_DATA_BITS(64), .ADDR_BITS(32), .BURST_LEN(BL),
        .BASE_ADDR(BASE), .ADDR_STEP(128), .REGION_LEN(256)
    ) dut (
        .mem_clk(mem_clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode), .loop_en(loop_en),
        .wr_burst_req(wr_burst_req), .wr_burst_len(wr_burst_len), .wr_burst_addr(wr_burst_addr),
        .wr_burst_data_req(wr_burst_data_req), .wr_burst_data(wr_burst_data), .wr_burst_finish(wr_burst_finish),
        .rd_burst_req(rd_burst_req), .rd_burst_len(rd_burst_len), .rd_burst_addr(rd_burst_addr),
        .rd_burst_data_valid(rd_burst_data_valid), .rd_burst_data(rd_burst_data), .rd_burst_finish(rd_burst_finish),
        .busy(busy), .done(done), .error(error), .err_cnt(err_cnt), .err_addr(err_addr), .pass_cnt(pass_cnt)
    );

    always #5 mem_clk = ~mem_clk;

    int          n_vec = 0, n_miss = 0;
    logic [63:0] exp_wd_q[$];
    logic [31:0] exp_wa_q[$], exp_ra_q[$];
    logic        mon_en = 1'b1, skip_wr = 1'b0, corrupt_all = 1'b0, corrupt_en = 1'b0;
    logic [31:0] c_addr = '0;
    int          c_beat = 0;
    logic [63:0] mem [logic [41:0]];
    logic        dreq_s = 1'b0;

    always @(posedge mem_clk) dreq_s <= wr_burst_data_req;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic miss(input string name);
        n_vec++;
        n_miss++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    function automatic logic [41:0] key(input logic [31:0] a, input int b);
        return {a, 10'(b)};
    endfunction

    function automatic logic [31:0] ref_step(input logic [31:0] s);
        int   taps[4] = '{31, 21, 1, 0};
        logic fb = 1'b0;
        for (int i = 0; i < 4; i++) fb = fb ^ s[taps[i]];
        return {s[30:0], fb};
    endfunction

    function automatic logic [63:0] exp_pat(input int m, input logic [31:0] a, input int k);
        logic [63:0] r;
        logic [31:0] w;
        logic [7:0]  b;
        r = '0;
        case (m)
            0: begin b = 8'(k); r = {8{b}}; end
            1: begin w = a + 32'(k); r = {w, w}; end
            2: r[k % 64] = 1'b1;
            default: begin
                w = a | 32'd1;
                for (int j = 0; j < k; j++) w = ref_step(w);
                r = {w, w};
            end
        endcase
        return r;
    endfunction

    task automatic push_burst(input int m, input logic [31:0] a);
        exp_wa_q.push_back(a);
        exp_ra_q.push_back(a);
        for (int k = 0; k < BL; k++) exp_wd_q.push_back(exp_pat(m, a, k));
    endtask

    task automatic pulse_start();
        @(negedge mem_clk) start = 1'b1;
        @(negedge mem_clk) start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge mem_clk) stop = 1'b1;
        @(negedge mem_clk) stop = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int lim);
        int c = 0;
        while (busy && c < lim) begin
            @(negedge mem_clk);
            c++;
        end
        if (busy) miss(name);
    endtask

    task automatic chk_queues_empty(input string name);
        chk(name, 64'(exp_wd_q.size() + exp_wa_q.size() + exp_ra_q.size()), 64'd0);
    endtask

    // Burst slave backed by a sparse memory; read beats can be corrupted on demand.
    initial begin
        int          st, s_req, s_cap, s_cnt;
        logic [31:0] s_addr;
        logic [41:0] kk;
        logic [63:0] d;
        st = 0; s_req = 0; s_cap = 0; s_cnt = 0; s_addr = '0;
        forever begin
            @(negedge mem_clk);
            wr_burst_data_req = 1'b0; wr_burst_finish = 1'b0;
            rd_burst_data_valid = 1'b0; rd_burst_finish = 1'b0;
            if (!rst_n) begin
                st = 0;
            end else begin
                if (st == 0) begin
                    if (wr_burst_req) begin
                        st = 1; s_addr = wr_burst_addr; s_req = 0; s_cap = 0;
                    end else if (rd_burst_req) begin
                        st = 2; s_addr = rd_burst_addr; s_cnt = 0;
                    end
                end
                if (st == 1) begin
                    if (skip_wr) begin
                        wr_burst_finish = 1'b1; st = 0;
                    end else begin
                        if (dreq_s) begin
                            mem[key(s_addr, s_cap)] = wr_burst_data;
                            s_cap++;
                        end
                        if (s_cap == BL) begin
                            wr_burst_finish = 1'b1; st = 0;
                        end else if (s_req < BL) begin
                            wr_burst_data_req = 1'b1; s_req++;
                        end
                    end
                end else if (st == 2) begin
                    kk = key(s_addr, s_cnt);
                    d = mem.exists(kk) ? mem[kk] : '1;
                    if (corrupt_all) d = '1;
                    if (corrupt_en && s_addr == c_addr && s_cnt == c_beat) d[0] = ~d[0];
                    rd_burst_data = d;
                    rd_burst_data_valid = 1'b1;
                    if (s_cnt == BL - 1) begin
                        rd_burst_finish = 1'b1; st = 0;
                    end
                    s_cnt++;
                end
            end
        end
    end

    // Monitor: pops expected write beats and burst addresses as the DUT presents them.
    initial begin
        logic pw, pr;
        pw = 1'b0; pr = 1'b0;
        forever begin
            @(negedge mem_clk);
            if (mon_en && rst_n) begin
                if (dreq_s) begin
                    if (exp_wd_q.size() == 0) miss("wr_data_extra");
                    else chk("wr_data", wr_burst_data, exp_wd_q.pop_front());
                end
                if (wr_burst_req && !pw) begin
                    if (exp_wa_q.size() == 0) miss("wr_burst_extra");
                    else chk("wr_addr", 64'(wr_burst_addr), 64'(exp_wa_q.pop_front()));
                end
                if (rd_burst_req && !pr) begin
                    if (exp_ra_q.size() == 0) miss("rd_burst_extra");
                    else chk("rd_addr", 64'(rd_burst_addr), 64'(exp_ra_q.pop_front()));
                end
            end
            pw = wr_burst_req;
            pr = rd_burst_req;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        repeat (3) @(negedge mem_clk);
        chk("rst_wr_req", wr_burst_req, 0);
        chk("rst_rd_req", rd_burst_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_wr_len", wr_burst_len, 10'd128);
        chk("rst_rd_len", rd_burst_len, 10'd128);
        chk("rst_wr_addr", wr_burst_addr, 0);
        chk("rst_wr_data", wr_burst_data, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_pass_cnt", pass_cnt, 0);
        @(negedge mem_clk) rst_n = 1'b1;

        // T1: byte-count pattern, clean single pass
        mode = 2'd0; loop_en = 1'b0;
        push_burst(0, BASE);
        push_burst(0, BASE + 32'h80);
        pulse_start();
        chk("t1_busy", busy, 1);
        wait_idle("t1_timeout", 5000);
        chk("t1_done", done, 1);
        chk("t1_pass", pass_cnt, 1);
        chk("t1_error", error, 0);
        chk("t1_err_cnt", err_cnt, 0);
        chk("t1_last_rd_addr", rd_burst_addr, 32'h0200_0080);
        chk("t1_mem_beat5", mem[key(BASE, 5)], 64'h0505_0505_0505_0505);
        chk_queues_empty("t1_queues");

        // T2: address pattern, bit 0 of beat 5 in the second burst flipped on read
        mode = 2'd1; corrupt_en = 1'b1; c_addr = BASE + 32'h80; c_beat = 5;
        push_burst(1, BASE);
        push_burst(1, BASE + 32'h80);
        pulse_start();
        chk("t2_done_cleared", done, 0);
        chk("t2_start_addr", wr_burst_addr, BASE);
        wait_idle("t2_timeout", 5000);
        corrupt_en = 1'b0;
        chk("t2_error", error, 1);
        chk("t2_err_cnt", err_cnt, 1);
        chk("t2_err_addr", err_addr, 32'h0200_0085);
        chk("t2_done", done, 1);
        chk("t2_pass", pass_cnt, 1);
        chk("t2_mem_b1_beat3", mem[key(BASE + 32'h80, 3)], 64'h0200_0083_0200_0083);
        chk_queues_empty("t2_queues");

        // T3: LFSR pattern looping; stop after the third pass lets one more pair finish
        mode = 2'd3; loop_en = 1'b1;
        for (int i = 0; i < 7; i++) push_burst(3, (i % 2 == 0) ? BASE : BASE + 32'h80);
        pulse_start();
        c = 0;
        while (pass_cnt != 16'd3 && c < 5000) begin
            @(negedge mem_clk);
            c++;
        end
        if (pass_cnt != 16'd3) miss("t3_pass_timeout");
        chk("t3_done_in_loop", done, 0);
        chk("t3_busy_in_loop", busy, 1);
        pulse_stop();
        wait_idle("t3_stop_timeout", 2000);
        loop_en = 1'b0;
        chk("t3_pass", pass_cnt, 3);
        chk("t3_done", done, 0);
        chk("t3_error", error, 0);
        chk("t3_lfsr_beat1", mem[key(BASE, 1)], 64'h0400_0003_0400_0003);
        chk("t3_lfsr_beat2", mem[key(BASE, 2)], 64'h0800_0006_0800_0006);
        chk_queues_empty("t3_queues");

        // T4: stop during the first write burst
        mode = 2'd2;
        push_burst(2, BASE);
        pulse_start();
        c = 0;
        while (!dreq_s && c < 100) begin
            @(negedge mem_clk);
            c++;
        end
        if (!dreq_s) miss("t4_write_timeout");
        repeat (10) @(negedge mem_clk);
        pulse_stop();
        wait_idle("t4_timeout", 2000);
        chk("t4_done", done, 0);
        chk("t4_pass", pass_cnt, 0);
        chk("t4_rd_addr", rd_burst_addr, BASE);
        chk("t4_walk_beat70", mem[key(BASE, 70)], 64'h0000_0000_0000_0040);
        repeat (5) @(negedge mem_clk);
        chk("t4_no_restart", wr_burst_req, 0);
        chk_queues_empty("t4_queues");

        // T5: one-cycle reset in the middle of a read burst
        mode = 2'd0;
        push_burst(0, BASE);
        push_burst(0, BASE + 32'h80);
        pulse_start();
        c = 0;
        while (!rd_burst_req && c < 1000) begin
            @(negedge mem_clk);
            c++;
        end
        if (!rd_burst_req) miss("t5_read_timeout");
        repeat (10) @(negedge mem_clk);
        @(posedge mem_clk) #2 rst_n = 1'b0;
        @(posedge mem_clk) #2 rst_n = 1'b1;
        @(negedge mem_clk);
        chk("t5_rst_rd_req", rd_burst_req, 0);
        chk("t5_rst_wr_req", wr_burst_req, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_rd_addr", rd_burst_addr, 0);
        chk("t5_rst_wr_addr", wr_burst_addr, 0);
        chk("t5_rst_wr_data", wr_burst_data, 0);
        exp_wd_q.delete(); exp_wa_q.delete(); exp_ra_q.delete();
        push_burst(0, BASE);
        push_burst(0, BASE + 32'h80);
        pulse_start();
        chk("t5_restart_addr", wr_burst_addr, BASE);
        wait_idle("t5_timeout", 5000);
        chk("t5_done", done, 1);
        chk("t5_pass", pass_cnt, 1);
        chk_queues_empty("t5_queues");

        // T6: every read beat corrupt, looping until err_cnt saturates
        mon_en = 1'b0; skip_wr = 1'b1; corrupt_all = 1'b1;
        mode = 2'd2; loop_en = 1'b1;
        pulse_start();
        repeat (2000) @(negedge mem_clk);
        pulse_start();
        chk("t6_start_ignored_busy", busy, 1);
        chk("t6_start_ignored_cnt", err_cnt > 16'd1000, 1);
        chk("t6_start_ignored_done", done, 0);
        c = 0;
        while (err_cnt != 16'hFFFF && c < 80000) begin
            @(negedge mem_clk);
            c++;
        end
        if (err_cnt != 16'hFFFF) miss("t6_saturate_timeout");
        repeat (300) @(negedge mem_clk);
        chk("t6_err_cnt_sat", err_cnt, 16'hFFFF);
        pulse_stop();
        wait_idle("t6_stop_timeout", 1000);
        chk("t6_error", error, 1);
        chk("t6_err_addr_first", err_addr, BASE);
        chk("t6_done", done, 0);
        mon_en = 1'b1; skip_wr = 1'b0; corrupt_all = 1'b0; loop_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
